rr_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one bus between N_MASTERS requesters.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 38 +++
 rtl/rr_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
//   N_MASTERS   default number of requesters
//   arb_vector  one bit per master (request / grant vectors)
//   NO_REQUEST  all-zero request vector
//   NO_GRANT    all-zero grant vector
//   arb_state_t arbiter FSM states
package bus_arb_pkg;

   localparam int unsigned N_MASTERS = 3;

   typedef logic [N_MASTERS-1:0] arb_vector;

   localparam arb_vector NO_REQUEST = '0;
   localparam arb_vector NO_GRANT   = '0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit,
// searching upward from the master after last_ptr and wrapping.
//   req       request vector, bit i = master i
//   last_ptr  index of the most recent owner
//   onehot_c  one-hot winner (zero when nobody requests)
//   id_c      winner index (zero when nobody requests)
//   valid_c   a winner exists
module rr_pick #(
   parameter int unsigned N_MASTERS = 3
) (
   input  logic [N_MASTERS-1:0]          req,
   input  logic [$clog2(N_MASTERS)-1:0]  last_ptr,
   output logic [N_MASTERS-1:0]          onehot_c,
   output logic [$clog2(N_MASTERS)-1:0]  id_c,
   output logic                          valid_c
);

   localparam int unsigned ID_W = $clog2(N_MASTERS);

   logic [ID_W-1:0] idx;

   // Rotated priority scan; the first hit (lowest offset) wins.
   always_comb begin
      onehot_c = '0;
      id_c     = '0;
      valid_c  = 1'b0;
      idx      = '0;
      for (int k = 1; k <= int'(N_MASTERS); k++) begin
         idx = ID_W'((int'(last_ptr) + k) % int'(N_MASTERS));
         if (!valid_c && req[idx]) begin
            onehot_c[idx] = 1'b1;
            id_c          = idx;
            valid_c       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one bus between N_MASTERS requesters.
// A grant is held until bus_ack or until the watchdog revokes it.
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   bus_req      request vector, bit i = master i
//   bus_ack      slave ack; ends the current tenure
//   bus_grant    one-hot or zero grant (registered)
//   grant_id     index of granted master, 0 when idle (registered)
//   bus_busy     high while a grant is held (registered)
//   bus_timeout  one-cycle pulse when the watchdog revokes a grant (registered)
module rr_bus_arbiter #(
   parameter int unsigned N_MASTERS = bus_arb_pkg::N_MASTERS,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          bus_req,
   input  logic                          bus_ack,
   output logic [N_MASTERS-1:0]          bus_grant,
   output logic [$clog2(N_MASTERS)-1:0]  grant_id,
   output logic                          bus_busy,
   output logic                          bus_timeout
);

   import bus_arb_pkg::*;

   localparam int unsigned ID_W  = $clog2(N_MASTERS);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t             state_q, state_d;
   logic [N_MASTERS-1:0]   grant_d;
   logic [ID_W-1:0]        id_d;
   logic [ID_W-1:0]        last_q, last_d;
   logic [CNT_W-1:0]       wd_q, wd_d;
   logic                   timeout_d;

   logic [N_MASTERS-1:0]   pick_onehot_c;
   logic [ID_W-1:0]        pick_id_c;
   logic                   pick_valid_c;

   // Winner search starts after the last owner, with its own bit still visible.
   rr_pick #(
      .N_MASTERS (N_MASTERS)
   ) u_pick (
      .req      (bus_req),
      .last_ptr (last_q),
      .onehot_c (pick_onehot_c),
      .id_c     (pick_id_c),
      .valid_c  (pick_valid_c)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bus_grant   <= '0;
         grant_id    <= '0;
         bus_busy    <= 1'b0;
         bus_timeout <= 1'b0;
         last_q      <= ID_W'(N_MASTERS - 1);
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         bus_grant   <= grant_d;
         grant_id    <= id_d;
         bus_busy    <= (state_d == GRANT);
         bus_timeout <= timeout_d;
         last_q      <= last_d;
         wd_q        <= wd_d;
      end
   end

   // Next-state, grant and watchdog logic.
   always_comb begin
      state_d   = state_q;
      grant_d   = bus_grant;
      id_d      = grant_id;
      last_d    = last_q;
      wd_d      = wd_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            grant_d = '0;
            id_d    = '0;
            wd_d    = '0;
            // A still-high bus_timeout marks the mandatory dead cycle after a revoke.
            if (pick_valid_c && !bus_timeout) begin
               grant_d = pick_onehot_c;
               id_d    = pick_id_c;
               last_d  = pick_id_c;
               state_d = GRANT;
            end
         end

         GRANT: begin
            if (bus_ack) begin
               wd_d = '0;
               if (pick_valid_c) begin
                  grant_d = pick_onehot_c;
                  id_d    = pick_id_c;
                  last_d  = pick_id_c;
               end else begin
                  grant_d = '0;
                  id_d    = '0;
                  state_d = IDLE;
               end
            end else if (wd_q >= CNT_W'(TIMEOUT - 1)) begin
               // Revoke; last_q keeps the revoked owner so it drops to lowest priority.
               grant_d   = '0;
               id_d      = '0;
               wd_d      = '0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wd_d = wd_q + CNT_W'(1);
            end
         end

         default: begin
            grant_d = '0;
            id_d    = '0;
            wd_d    = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: a tenure-level reference model
// predicts each registered output per clock, a monitor compares on the
// falling edge, and directed scenarios add explicit boundary checks.
module tb_rr_bus_arbiter;

   import bus_arb_pkg::*;

   localparam int unsigned NM  = N_MASTERS;
   localparam int unsigned TMO = 15;
   localparam int unsigned IDW = $clog2(NM);

   typedef struct packed {
      arb_vector       grant;
      logic [IDW-1:0]  id;
      logic            busy;
      logic            tmo;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   arb_vector       bus_req = NO_REQUEST;
   logic            bus_ack = 1'b0;
   arb_vector       bus_grant;
   logic [IDW-1:0]  grant_id;
   logic            bus_busy;
   logic            bus_timeout;

   int checks   = 0;
   int failures = 0;

   exp_t sb_q[$];

   rr_bus_arbiter #(
      .N_MASTERS (NM),
      .TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_req     (bus_req),
      .bus_ack     (bus_ack),
      .bus_grant   (bus_grant),
      .grant_id    (grant_id),
      .bus_busy    (bus_busy),
      .bus_timeout (bus_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Owner -1 means the bus is free; held counts ack-less cycles of the tenure.
   int m_owner = -1;
   int m_last  = NM - 1;
   int m_held  = 0;
   bit m_cool  = 1'b0;
   bit m_tmo   = 1'b0;

   function automatic int rr_winner(input arb_vector req, input int last);
      for (int k = 1; k <= int'(NM); k++) begin
         int i;
         i = (last + k) % int'(NM);
         if (req[IDW'(i)]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      int   w;
      m_tmo = 1'b0;
      if (reset) begin
         m_owner = -1;
         m_last  = NM - 1;
         m_held  = 0;
         m_cool  = 1'b0;
      end else if (m_owner < 0) begin
         if (!m_cool) begin
            w = rr_winner(bus_req, m_last);
            if (w >= 0) begin
               m_owner = w;
               m_last  = w;
               m_held  = 0;
            end
         end
         m_cool = 1'b0;
      end else if (bus_ack) begin
         w       = rr_winner(bus_req, m_last);
         m_owner = w;
         if (w >= 0) m_last = w;
         m_held  = 0;
      end else begin
         m_held++;
         if (m_held == int'(TMO)) begin
            m_owner = -1;
            m_held  = 0;
            m_tmo   = 1'b1;
            m_cool  = 1'b1;
         end
      end
      e.grant = (m_owner >= 0) ? (arb_vector'(1) << m_owner) : NO_GRANT;
      e.id    = (m_owner >= 0) ? IDW'(m_owner) : '0;
      e.busy  = (m_owner >= 0);
      e.tmo   = m_tmo;
      sb_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk("grant",    int'(bus_grant),   int'(e.grant));
         chk("grant_id", int'(grant_id),    int'(e.id));
         chk("busy",     int'(bus_busy),    int'(e.busy));
         chk("timeout",  int'(bus_timeout), int'(e.tmo));
         chk("onehot0",  int'($onehot0(bus_grant)), 1);
         chk("busy_eq_grant", int'(bus_busy), int'(bus_grant != NO_GRANT));
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge: apply inputs, return at the next falling edge.
   task automatic cyc(input arb_vector req, input logic ack);
      bus_req = req;
      bus_ack = ack;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(NO_REQUEST, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int ack_pct;
      arb_vector r;

      @(negedge clk);
      @(negedge clk);
      chk("reset_grant", int'(bus_grant), 0);
      chk("reset_busy",  int'(bus_busy),  0);
      reset = 1'b0;

      // First grant and hold without ack.
      cyc(3'b110, 1'b0);
      chk("s1_grant", int'(bus_grant), 3'b010);
      chk("s1_id",    int'(grant_id),  1);
      repeat (3) cyc(3'b110, 1'b0);
      chk("s1_hold",  int'(bus_grant), 3'b010);
      cyc(NO_REQUEST, 1'b1);

      // Fairness with continuous requests and ack every cycle.
      do_reset();
      cyc(3'b111, 1'b1); chk("s2_g0", int'(bus_grant), 3'b001);
      cyc(3'b111, 1'b1); chk("s2_g1", int'(bus_grant), 3'b010);
      cyc(3'b111, 1'b1); chk("s2_g2", int'(bus_grant), 3'b100);
      cyc(3'b111, 1'b1); chk("s2_g3", int'(bus_grant), 3'b001);
      cyc(NO_REQUEST, 1'b1);

      // Watchdog revoke and the dead cycle after it.
      do_reset();
      cyc(3'b001, 1'b0);
      chk("s3_grant", int'(bus_grant), 3'b001);
      repeat (TMO - 1) cyc(3'b011, 1'b0);
      chk("s3_hold",   int'(bus_grant),   3'b001);
      chk("s3_no_tmo", int'(bus_timeout), 0);
      cyc(3'b011, 1'b0);
      chk("s3_revoked", int'(bus_grant),   0);
      chk("s3_tmo",     int'(bus_timeout), 1);
      cyc(3'b011, 1'b0);
      chk("s3_dead",     int'(bus_grant),   0);
      chk("s3_tmo_drop", int'(bus_timeout), 0);
      cyc(3'b011, 1'b0);
      chk("s3_regrant",  int'(bus_grant), 3'b010);

      // Owner drops request, ack with nobody waiting, ack while idle.
      repeat (2) cyc(NO_REQUEST, 1'b0);
      chk("s4_hold", int'(bus_grant), 3'b010);
      cyc(NO_REQUEST, 1'b1);
      chk("s4_idle_grant", int'(bus_grant), 0);
      chk("s4_idle_busy",  int'(bus_busy),  0);
      cyc(NO_REQUEST, 1'b1);
      chk("s4_ack_ignored", int'(bus_grant), 0);

      // Ack on the last watchdog cycle wins over the timeout.
      cyc(3'b001, 1'b0);
      chk("s5_grant", int'(bus_grant), 3'b001);
      repeat (TMO - 1) cyc(3'b001, 1'b0);
      cyc(3'b100, 1'b1);
      chk("s5_handover", int'(bus_grant),   3'b100);
      chk("s5_no_tmo",   int'(bus_timeout), 0);

      // Asynchronous reset mid-tenure.
      cyc(3'b100, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("s6_async_grant", int'(bus_grant), 0);
      chk("s6_async_busy",  int'(bus_busy),  0);
      @(negedge clk);
      reset = 1'b0;
      cyc(3'b101, 1'b0);
      chk("s6_after_reset", int'(bus_grant), 3'b001);

      // Randomized traffic with varying ack density to reach timeouts and handovers.
      ack_pct = 50;
      for (int n = 0; n < 1200; n++) begin
         if (n % 60 == 0) begin
            case ($urandom_range(0, 3))
               0:       ack_pct = 0;
               1:       ack_pct = 8;
               2:       ack_pct = 50;
               default: ack_pct = 95;
            endcase
         end
         r = arb_vector'($urandom_range(0, (1 << NM) - 1));
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
            cyc(r, 1'b0);
            reset = 1'b0;
         end else begin
            cyc(r, ($urandom_range(0, 99) < ack_pct));
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
